jt12_eg_mon: RTL
================

Name: jt12_eg_mon

Overview:
- Envelope read-back monitor. Sits downstream of the envelope generator and consumes its time-multiplexed 10-bit attenuation stream (eg_V, one operator slot per clk_en).
- Realigns the stream to slot numbers using the zero frame marker.
- Serves single-slot snapshot reads to the CPU/debug bus through a req/ack handshake.
- Publishes per-frame silence and loudest-slot status for voice-allocation and power-gating logic.

Parameters:
- SLOTS, 24, operator slots per frame; the slot counter wraps at SLOTS-1.
- SIL_TH, 10'h3F0, attenuation at or above which a slot counts as silent.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- clk_en  in  1  slot-rate enable; all state advances only when clk_en=1, except the rd_ack pulse clear
- zero  in  1  frame marker; when high with clk_en, the eg_V sampled in that cycle is slot 0
- eg_V  in  10  envelope attenuation for the current slot (0 = loudest, 3FF = off)
- rd_req  in  1  read request, level; sampled only in IDLE
- rd_slot  in  5  slot to read, sampled with rd_req
- rd_ack  out  1  one-clk pulse when rd_data/rd_err are valid
- rd_data  out  10  captured attenuation of rd_slot
- rd_err  out  1  set with rd_ack when rd_slot >= SLOTS
- synced  out  1  high once the first zero has been seen
- sil_mask  out  SLOTS  bit n = slot n silent in the last complete frame
- all_silent  out  1  every slot silent in the last complete frame
- frame_min  out  10  minimum eg_V over the last complete frame
- min_slot  out  5  slot holding frame_min; lowest index wins ties

Behaviour:
- Reset values: rd_ack=0, rd_data=3FF, rd_err=0, synced=0, sil_mask=all ones, all_silent=1, frame_min=3FF, min_slot=0, state=IDLE.
- Slot tracking:
  - cur_slot = zero ? 0 : cnt.
  - On clk_en: cnt <= (cur_slot==SLOTS-1) ? 0 : cur_slot+1.
  - zero at an unexpected point resynchronises immediately; the frame in progress is discarded and frame outputs are not updated.
  - synced sets on the first zero and clears only by reset.
- Frame statistics (only while synced; sample on each clk_en):
  - Accumulate sil_acc[cur_slot] = (eg_V >= SIL_TH).
  - Accumulate a running minimum with its slot; use strict < so the lowest index is kept on ties.
  - On the clk_en where cur_slot==SLOTS-1, with no intervening resync, commit the frame in the next cycle: sil_mask, all_silent = &sil_mask, frame_min, min_slot.
  - Accumulators restart at slot 0.
- Read FSM states:
  - IDLE -> rd_req=1:
    - rd_slot >= SLOTS: go to DONE with rd_err=1, rd_data=3FF.
    - otherwise: latch the slot and go to WAIT.
  - WAIT -> clk_en & synced & cur_slot==latched slot: capture eg_V into rd_data, rd_err=0, go to DONE.
    - WAIT holds indefinitely while unsynced.
    - A resync during WAIT does not abort; matching continues on the new alignment.
  - DONE: rd_ack=1 for exactly one clk, independent of clk_en; next state is IDLE.
  - A new request is accepted no earlier than the clk after rd_ack. rd_req still high then starts a new read, i.e. back-to-back reads are allowed.
  - rd_slot changes during WAIT are ignored.
  - Latency from IDLE acceptance to rd_ack is 1..SLOTS+1 clk_en slots plus 1 clk.
- rd_data and rd_err hold their values until the next capture.
- rst_n low mid-read aborts with no ack; all outputs return to their reset values.

Test Plan:
- Reset, then zero every 24 clk_en with eg_V = 100+slot -> synced=1 after the first zero. After the first full frame: frame_min=100, min_slot=0, sil_mask=0, all_silent=0.
- rd_req with rd_slot=7, issued mid-frame at slot 12 -> rd_ack after 19 clk_en with rd_data=107, rd_err=0. rd_ack is high exactly 1 clk.
- rd_req with rd_slot=24 -> rd_ack on the 2nd clk, rd_err=1, rd_data=3FF, no wait for the stream.
- All slots eg_V=3FF except slot 5=3EF -> sil_mask=~(1<<5), all_silent=0. Next frame all 3FF -> all_silent=1, frame_min=3FF, min_slot=0.
- Equal minima: slots 3 and 9 both 050 -> min_slot=3.
- rd_req before any zero -> no ack. Once zero arrives, rd_ack is issued at the requested slot. Assert rst_n low during WAIT -> no ack, outputs at reset values.

Source files
------------

// File: rtl/jt12_eg_mon.sv
// Envelope read-back monitor: realigns the time-multiplexed EG attenuation stream
// to slot numbers, serves single-slot snapshot reads and publishes per-frame status.
module jt12_eg_mon #(
   parameter int unsigned SLOTS  = 24,
   parameter logic [9:0]  SIL_TH = 10'h3F0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clk_en,
   input  logic             zero,
   input  logic [9:0]       eg_V,
   input  logic             rd_req,
   input  logic [4:0]       rd_slot,
   output logic             rd_ack,
   output logic [9:0]       rd_data,
   output logic             rd_err,
   output logic             synced,
   output logic [SLOTS-1:0] sil_mask,
   output logic             all_silent,
   output logic [9:0]       frame_min,
   output logic [4:0]       min_slot
);

   localparam logic [4:0] LAST_SLOT = 5'(SLOTS - 1);
   localparam logic [5:0] NUM_SLOTS = 6'(SLOTS);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} rd_state_t;

   rd_state_t        state;
   logic [4:0]       cnt;
   logic [4:0]       cur_slot;
   logic [4:0]       req_slot;
   logic             sync_now;
   logic             sil_now;
   logic             take_min;
   logic [SLOTS-1:0] sil_acc;
   logic [9:0]       min_acc;
   logic [4:0]       min_idx;
   logic             commit_p;

   // zero forces slot 0 and counts as synced in the very cycle it arrives
   always_comb begin
      cur_slot = zero ? 5'd0 : cnt;
      sync_now = synced | zero;
      sil_now  = (eg_V >= SIL_TH);
      take_min = (cur_slot == 5'd0) | (eg_V < min_acc);
   end

   // Slot alignment and frame accumulation; a frame is published one clk after its last slot
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt        <= 5'd0;
         synced     <= 1'b0;
         sil_acc    <= '1;
         min_acc    <= 10'h3FF;
         min_idx    <= 5'd0;
         commit_p   <= 1'b0;
         sil_mask   <= '1;
         all_silent <= 1'b1;
         frame_min  <= 10'h3FF;
         min_slot   <= 5'd0;
      end else begin
         commit_p <= 1'b0;
         if (clk_en) begin
            cnt <= (cur_slot == LAST_SLOT) ? 5'd0 : cur_slot + 5'd1;
            if (zero) synced <= 1'b1;
            if (sync_now) begin
               sil_acc[cur_slot] <= sil_now;
               if (take_min) begin
                  min_acc <= eg_V;
                  min_idx <= cur_slot;
               end
               commit_p <= (cur_slot == LAST_SLOT);
            end
         end
         if (commit_p) begin
            sil_mask   <= sil_acc;
            all_silent <= &sil_acc;
            frame_min  <= min_acc;
            min_slot   <= min_idx;
         end
      end
   end

   // Snapshot read handshake; rd_ack is high for the single clk spent in DONE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         req_slot <= 5'd0;
         rd_ack   <= 1'b0;
         rd_data  <= 10'h3FF;
         rd_err   <= 1'b0;
      end else begin
         rd_ack <= 1'b0;
         case (state)
            IDLE: begin
               if (rd_req) begin
                  if ({1'b0, rd_slot} >= NUM_SLOTS) begin
                     rd_err  <= 1'b1;
                     rd_data <= 10'h3FF;
                     rd_ack  <= 1'b1;
                     state   <= DONE;
                  end else begin
                     req_slot <= rd_slot;
                     state    <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (clk_en && sync_now && (cur_slot == req_slot)) begin
                  rd_data <= eg_V;
                  rd_err  <= 1'b0;
                  rd_ack  <= 1'b1;
                  state   <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
